// File: rtl/lamp_conflict_monitor_pkg.sv
// Shared types and constants for the intersection lamp conflict monitor.
package tlc_mon_pkg;

    typedef enum logic [1:0] {PH_R, PH_G, PH_Y, PH_INV} phase_t;
    typedef enum logic [1:0] {ARMING, RUN, FAULT} state_t;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_CONFLICT = 3'd1;
    localparam logic [2:0] FC_ONEHOT   = 3'd2;
    localparam logic [2:0] FC_SEQ      = 3'd3;
    localparam logic [2:0] FC_YSHORT   = 3'd4;
    localparam logic [2:0] FC_STUCK    = 3'd5;

    localparam int FV_CONFLICT = 0;
    localparam int FV_ONEHOT   = 1;
    localparam int FV_SEQ      = 2;
    localparam int FV_YSHORT   = 3;
    localparam int FV_STUCK    = 4;

    function automatic phase_t decode_phase(input logic r, input logic y, input logic g);
        case ({r, y, g})
            3'b100:  decode_phase = PH_R;
            3'b010:  decode_phase = PH_Y;
            3'b001:  decode_phase = PH_G;
            default: decode_phase = PH_INV;
        endcase
    endfunction

    // Lowest code wins when several checks fire in the same sample.
    function automatic logic [2:0] first_code(input logic [4:0] v);
        if (v[FV_CONFLICT])    first_code = FC_CONFLICT;
        else if (v[FV_ONEHOT]) first_code = FC_ONEHOT;
        else if (v[FV_SEQ])    first_code = FC_SEQ;
        else if (v[FV_YSHORT]) first_code = FC_YSHORT;
        else if (v[FV_STUCK])  first_code = FC_STUCK;
        else                   first_code = FC_NONE;
    endfunction

endpackage

// File: rtl/lamp_conflict_monitor_dir_tracker.sv
// One direction's phase decode, previous phase, yellow/hold counters and raw check flags.
// Counters track every sample regardless of top state so history is valid on arming.
module lamp_dir_tracker
    import tlc_mon_pkg::*;
#(
    parameter int YELLOW_MIN = 500,
    parameter int TIMEOUT    = 4000,
    parameter int CWIDTH     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic r,
    input  logic y,
    input  logic g,
    output logic onehot_err,
    output logic seq_err,
    output logic yshort_err,
    output logic stuck_err,
    output logic non_red,
    output logic valid
);
    localparam logic [CWIDTH-1:0] CMAX = '1;
    localparam logic [CWIDTH-1:0] YMIN = CWIDTH'(YELLOW_MIN);
    localparam logic [CWIDTH-1:0] TMO  = CWIDTH'(TIMEOUT);

    phase_t            cur;
    phase_t            prev;
    logic [CWIDTH-1:0] ycnt;
    logic [CWIDTH-1:0] hcnt;
    logic              same;

    assign cur  = decode_phase(r, y, g);
    assign same = (cur == prev);

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev <= PH_R;
            ycnt <= '0;
            hcnt <= '0;
        end else begin
            prev <= cur;
            if (cur == PH_Y)
                ycnt <= (ycnt == CMAX) ? ycnt : ycnt + 1'b1;
            else
                ycnt <= '0;
            if (same)
                hcnt <= (hcnt == CMAX) ? hcnt : hcnt + 1'b1;
            else
                hcnt <= CWIDTH'(1);
        end
    end

    assign onehot_err = (cur == PH_INV);
    assign seq_err    = (prev == PH_G && cur == PH_R) ||
                        (prev == PH_Y && cur == PH_G) ||
                        (prev == PH_R && cur == PH_Y);
    // ycnt still holds the length of the yellow run that just ended.
    assign yshort_err = (prev == PH_Y) && (cur == PH_R) && (ycnt < YMIN);
    assign stuck_err  = same && (hcnt == TMO);
    assign non_red    = (cur == PH_G) || (cur == PH_Y);
    assign valid      = (cur != PH_INV);

endmodule

// File: rtl/lamp_conflict_monitor.sv
// Intersection lamp safety monitor: registers lamps, checks both directions, latches first fault.
// Fault appears two cycles after the offending lamp pattern; cleared only by clr_fault in FAULT.
module lamp_conflict_monitor
    import tlc_mon_pkg::*;
#(
    parameter int YELLOW_MIN = 500,
    parameter int TIMEOUT    = 4000,
    parameter int ARM_CYCLES = 4,
    parameter int CWIDTH     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ns_red,
    input  logic       ns_yellow,
    input  logic       ns_green,
    input  logic       ew_red,
    input  logic       ew_yellow,
    input  logic       ew_green,
    input  logic       clr_fault,
    output logic       armed,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [4:0] fault_vec
);
    localparam int          AW       = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYCLES - 1);

    logic [2:0]    ns_s, ew_s;
    logic          ns_oh, ns_seq, ns_ys, ns_st, ns_nr, ns_ok;
    logic          ew_oh, ew_seq, ew_ys, ew_st, ew_nr, ew_ok;
    logic          conflict, clean;
    logic [4:0]    fired;
    logic [AW-1:0] arm_cnt;
    state_t        state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ns_s <= '0;
            ew_s <= '0;
        end else begin
            ns_s <= {ns_red, ns_yellow, ns_green};
            ew_s <= {ew_red, ew_yellow, ew_green};
        end
    end

    lamp_dir_tracker #(.YELLOW_MIN(YELLOW_MIN), .TIMEOUT(TIMEOUT), .CWIDTH(CWIDTH)) u_ns (
        .clk(clk), .rst(rst), .r(ns_s[2]), .y(ns_s[1]), .g(ns_s[0]),
        .onehot_err(ns_oh), .seq_err(ns_seq), .yshort_err(ns_ys), .stuck_err(ns_st),
        .non_red(ns_nr), .valid(ns_ok)
    );

    lamp_dir_tracker #(.YELLOW_MIN(YELLOW_MIN), .TIMEOUT(TIMEOUT), .CWIDTH(CWIDTH)) u_ew (
        .clk(clk), .rst(rst), .r(ew_s[2]), .y(ew_s[1]), .g(ew_s[0]),
        .onehot_err(ew_oh), .seq_err(ew_seq), .yshort_err(ew_ys), .stuck_err(ew_st),
        .non_red(ew_nr), .valid(ew_ok)
    );

    assign conflict = ns_nr & ew_nr;
    assign clean    = ns_ok & ew_ok & ~conflict;

    // Conflict is watched in every state; the rest only once history is trusted.
    always_comb begin
        fired = '0;
        fired[FV_CONFLICT] = conflict;
        if (state == RUN) begin
            fired[FV_ONEHOT] = ns_oh | ew_oh;
            fired[FV_SEQ]    = ns_seq | ew_seq;
            fired[FV_YSHORT] = ns_ys | ew_ys;
            fired[FV_STUCK]  = ns_st | ew_st;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ARMING;
            arm_cnt    <= '0;
            armed      <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            fault_vec  <= '0;
        end else begin
            case (state)
                ARMING: begin
                    if (fired != '0) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= first_code(fired);
                        fault_vec  <= fired;
                        arm_cnt    <= '0;
                    end else if (clean) begin
                        if (arm_cnt == ARM_LAST) begin
                            state   <= RUN;
                            armed   <= 1'b1;
                            arm_cnt <= '0;
                        end else begin
                            arm_cnt <= arm_cnt + 1'b1;
                        end
                    end else begin
                        arm_cnt <= '0;
                    end
                end
                RUN: begin
                    if (fired != '0) begin
                        state      <= FAULT;
                        armed      <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= first_code(fired);
                        fault_vec  <= fired;
                    end
                end
                FAULT: begin
                    if (clr_fault && fired == '0) begin
                        state      <= ARMING;
                        arm_cnt    <= '0;
                        fault      <= 1'b0;
                        fault_code <= FC_NONE;
                        fault_vec  <= '0;
                    end else begin
                        fault_vec  <= fault_vec | fired;
                    end
                end
                default: begin
                    state   <= ARMING;
                    arm_cnt <= '0;
                    armed   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Scoreboard bench for lamp_conflict_monitor: expected output bundles are queued with a
// due cycle when stimulus is driven and compared on the falling edge of that cycle.
module tb_lamp_conflict_monitor;
    localparam int YM = 4;
    localparam int TO = 20;
    localparam int AC = 2;

    localparam logic [2:0] L_R   = 3'b100;
    localparam logic [2:0] L_Y   = 3'b010;
    localparam logic [2:0] L_G   = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ns_red = 1'b0, ns_yellow = 1'b0, ns_green = 1'b0;
    logic       ew_red = 1'b0, ew_yellow = 1'b0, ew_green = 1'b0;
    logic       clr_fault = 1'b0;
    logic       armed, fault;
    logic [2:0] fault_code;
    logic [4:0] fault_vec;

    lamp_conflict_monitor #(
        .YELLOW_MIN(YM), .TIMEOUT(TO), .ARM_CYCLES(AC), .CWIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .clr_fault(clr_fault),
        .armed(armed), .fault(fault), .fault_code(fault_code), .fault_vec(fault_vec)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        string      tag;
        logic [9:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   li       = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp_v);
        end
    endtask

    // Bundle layout: {armed, fault, fault_code[2:0], fault_vec[4:0]}
    task automatic expect_at(input int dly, input string tag, input logic a, input logic f,
                             input logic [2:0] c, input logic [4:0] v);
        exp_t e;
        e.at  = cyc + dly;
        e.tag = tag;
        e.v   = {a, f, c, v};
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                chk(sb[i].tag, {22'b0, armed, fault, fault_code, fault_vec}, {22'b0, sb[i].v});
                sb.delete(i);
            end
        end
    end

    function automatic logic [2:0] ns_of(input int i);
        if (i < 8)       return L_G;
        else if (i < 12) return L_Y;
        else             return L_R;
    endfunction

    function automatic logic [2:0] ew_of(input int i);
        if (i < 12)      return L_R;
        else if (i < 20) return L_G;
        else             return L_Y;
    endfunction

    task automatic drive(input logic [2:0] ns, input logic [2:0] ew);
        {ns_red, ns_yellow, ns_green} = ns;
        {ew_red, ew_yellow, ew_green} = ew;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_legal();
        drive(ns_of(li % 24), ew_of(li % 24));
        li++;
    endtask

    task automatic legal_ticks(input int n);
        repeat (n) begin
            drive_legal();
            tick();
        end
    endtask

    task automatic advance_to(input int ph);
        while (li % 24 != ph) begin
            drive_legal();
            tick();
        end
    endtask

    task automatic clear_and_arm(input string tag);
        legal_ticks(2);
        drive_legal();
        clr_fault = 1'b1;
        expect_at(1, {tag, "_clr"}, 1'b0, 1'b0, 3'd0, 5'b00000);
        expect_at(2, {tag, "_arming"}, 1'b0, 1'b0, 3'd0, 5'b00000);
        expect_at(3, {tag, "_rearmed"}, 1'b1, 1'b0, 3'd0, 5'b00000);
        tick();
        clr_fault = 1'b0;
        legal_ticks(2);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(L_OFF, L_OFF);
        tick();
        tick();
        expect_at(1, "reset_state", 1'b0, 1'b0, 3'd0, 5'b00000);
        tick();
        tick();

        // Five legal cycles; arming completes after two clean samples.
        rst = 1'b1;
        li  = 0;
        for (int k = 0; k < 120; k++) begin
            drive_legal();
            expect_at(2, "legal", (k >= 1), 1'b0, 3'd0, 5'b00000);
            tick();
        end

        // Single-cycle both-green conflict while EW is already green.
        advance_to(14);
        drive(L_G, L_G);
        li++;
        expect_at(1, "conflict_latency", 1'b1, 1'b0, 3'd0, 5'b00000);
        expect_at(2, "conflict", 1'b0, 1'b1, 3'd1, 5'b00001);
        tick();
        legal_ticks(2);
        drive_legal();
        expect_at(1, "conflict_hold", 1'b0, 1'b1, 3'd1, 5'b00001);
        tick();
        clear_and_arm("conflict");

        // Three-sample yellow is short.
        advance_to(8);
        repeat (3) begin
            drive(L_Y, L_R);
            li++;
            tick();
        end
        drive(L_R, L_R);
        li++;
        expect_at(1, "yshort_latency", 1'b1, 1'b0, 3'd0, 5'b00000);
        expect_at(2, "yshort", 1'b0, 1'b1, 3'd4, 5'b01000);
        tick();
        clear_and_arm("yshort");

        // Exactly YELLOW_MIN yellow samples is accepted.
        advance_to(12);
        drive_legal();
        expect_at(2, "yellow_exact", 1'b1, 1'b0, 3'd0, 5'b00000);
        tick();

        // G->R on NS together with EW dark: ONEHOT outranks SEQ.
        advance_to(3);
        drive(L_R, L_OFF);
        li++;
        expect_at(2, "onehot_seq", 1'b0, 1'b1, 3'd2, 5'b00110);
        tick();
        clear_and_arm("onehot");

        // Hold NS G / EW R: the 20th sample is fine, the 21st trips STUCK.
        advance_to(0);
        for (int n = 1; n <= 21; n++) begin
            drive(L_G, L_R);
            li++;
            if (n == 20) expect_at(2, "stuck_20", 1'b1, 1'b0, 3'd0, 5'b00000);
            if (n == 21) expect_at(2, "stuck_21", 1'b0, 1'b1, 3'd5, 5'b10000);
            tick();
        end

        // clr_fault during a persisting conflict is refused and the conflict bit is added.
        drive(L_G, L_G);
        tick();
        drive(L_G, L_G);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        drive(L_G, L_G);
        expect_at(1, "clr_blocked", 1'b0, 1'b1, 3'd5, 5'b10001);
        tick();
        li = 12;
        clear_and_arm("clr_retry");

        // Reset in the middle of an NS yellow.
        advance_to(8);
        drive_legal();
        expect_at(1, "pre_reset", 1'b1, 1'b0, 3'd0, 5'b00000);
        tick();
        drive_legal();
        rst = 1'b0;
        expect_at(1, "reset_mid", 1'b0, 1'b0, 3'd0, 5'b00000);
        tick();
        drive_legal();
        expect_at(1, "reset_held", 1'b0, 1'b0, 3'd0, 5'b00000);
        tick();
        tick();
        tick();

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
